// File: rtl/dram_responder_pkg.sv
// Shared definitions for the core data-RAM port: request codes, latched request
// format and small code-decoding helpers used by the responder and the core control unit.
package dram_responder_pkg;

  localparam logic [1:0] DRAM_CODE_IDLE = 2'b00;
  localparam logic [1:0] DRAM_CODE_REQ  = 2'b01;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } dram_op_e;

  typedef struct packed {
    dram_op_e    op;
    logic [15:0] addr;
    logic [7:0]  data;
  } port_req_t;

  function automatic logic is_req(input logic [1:0] code);
    return code == DRAM_CODE_REQ;
  endfunction

  // Codes 2'b1x are reserved: they act as idle but flag an overrun.
  function automatic logic is_illegal(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/dram_responder_bank.sv
// Single-port 8-bit RAM with one-cycle synchronous read and write.
// Contents and read register are intentionally not reset.
module dram_bank #(
  parameter int MEM_ADDR_W = 12
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [MEM_ADDR_W-1:0] i_addr,
  input  logic [7:0]            i_wdata,
  output logic [7:0]            o_rdata
);

  logic [7:0] r_mem [2**MEM_ADDR_W];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dram_responder.sv
// Memory-side responder for the core data-RAM port: per-port edge-detected request latch,
// round-robin arbitration onto one shared single-port RAM, and per-port registered read return.
module dram_responder
  import dram_responder_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [16*NUM_CORES-1:0] i_dram_addr,
  input  logic [2*NUM_CORES-1:0]  i_dram_read,
  input  logic [2*NUM_CORES-1:0]  i_dram_write,
  input  logic [8*NUM_CORES-1:0]  i_dram_out,
  output logic [8*NUM_CORES-1:0]  o_dram_in,
  output logic [NUM_CORES-1:0]    o_rd_valid,
  output logic [NUM_CORES-1:0]    o_wr_done,
  output logic [NUM_CORES-1:0]    o_overrun,
  output logic                    o_busy
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0] r_rd_prev;
  logic [NUM_CORES-1:0] r_wr_prev;
  logic [NUM_CORES-1:0] r_pend;
  logic [NUM_CORES-1:0] r_ovr;
  logic [NUM_CORES-1:0] r_rd_valid;
  logic [NUM_CORES-1:0] r_wr_done;
  logic [PTR_W-1:0]     r_ptr;
  port_req_t            r_lat [NUM_CORES];

  logic [NUM_CORES-1:0] w_rd_req;
  logic [NUM_CORES-1:0] w_wr_req;
  logic [NUM_CORES-1:0] w_capture;
  logic [NUM_CORES-1:0] w_wr_sel;
  logic [NUM_CORES-1:0] w_ovr_set;
  logic [NUM_CORES-1:0] w_grant;
  logic                 w_gnt_any;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [PTR_W-1:0]     w_ptr_nxt;
  port_req_t            w_sel;
  logic                 w_sel_rd;
  logic                 w_sel_wr;
  logic [7:0]           w_rdata;
  logic                 w_unused_addr;

  // Stage 0: request detection per port (edge on code 00 -> 01)
  for (genvar p = 0; p < NUM_CORES; p++) begin : g_port
    logic [1:0] w_rd_code;
    logic [1:0] w_wr_code;
    logic       w_rd_edge;
    logic       w_wr_edge;
    logic       w_any_edge;
    logic [7:0] r_hold;

    assign w_rd_code  = i_dram_read[2*p +: 2];
    assign w_wr_code  = i_dram_write[2*p +: 2];
    assign w_rd_req[p] = is_req(w_rd_code);
    assign w_wr_req[p] = is_req(w_wr_code);
    assign w_rd_edge  = w_rd_req[p] & ~r_rd_prev[p];
    assign w_wr_edge  = w_wr_req[p] & ~r_wr_prev[p];
    assign w_any_edge = w_rd_edge | w_wr_edge;

    // A simultaneous read+write edge keeps the write; the read is the dropped half.
    assign w_capture[p] = w_any_edge & ~r_pend[p];
    assign w_wr_sel[p]  = w_wr_edge;
    assign w_ovr_set[p] = (w_any_edge & r_pend[p]) | (w_rd_edge & w_wr_edge) |
                          is_illegal(w_rd_code) | is_illegal(w_wr_code);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_hold <= '0;
      end else if (r_rd_valid[p]) begin
        r_hold <= w_rdata;
      end
    end

    // Fresh RAM data shows in the pulse cycle, then the held copy takes over.
    assign o_dram_in[8*p +: 8] = r_rd_valid[p] ? w_rdata : r_hold;
  end

  always_ff @(posedge i_clk) begin
    for (int p = 0; p < NUM_CORES; p++) begin
      if (w_capture[p]) begin
        r_lat[p].op   <= w_wr_sel[p] ? OP_WR : OP_RD;
        r_lat[p].addr <= i_dram_addr[16*p +: 16];
        r_lat[p].data <= i_dram_out[8*p +: 8];
      end
    end
  end

  // Stage 1: round-robin grant from registered pending flags, RAM access
  always_comb begin
    int w_idx;
    w_grant   = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_CORES;
      if (!w_gnt_any && r_pend[w_idx]) begin
        w_gnt_any      = 1'b1;
        w_gnt_idx      = w_idx[PTR_W-1:0];
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel     = r_lat[w_gnt_idx];
  assign w_sel_wr  = w_gnt_any & (w_sel.op == OP_WR);
  assign w_sel_rd  = w_gnt_any & (w_sel.op == OP_RD);

  // Upper address bits alias onto the RAM; they are intentionally discarded.
  assign w_unused_addr = ^w_sel.addr;

  dram_bank #(
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_bank (
    .i_clk   (i_clk),
    .i_en    (w_gnt_any),
    .i_we    (w_sel_wr),
    .i_addr  (w_sel.addr[MEM_ADDR_W-1:0]),
    .i_wdata (w_sel.data),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_prev  <= '0;
      r_wr_prev  <= '0;
      r_pend     <= '0;
      r_ovr      <= '0;
      r_rd_valid <= '0;
      r_wr_done  <= '0;
      r_ptr      <= '0;
    end else begin
      r_rd_prev  <= w_rd_req;
      r_wr_prev  <= w_wr_req;
      r_pend     <= (r_pend & ~w_grant) | w_capture;
      r_ovr      <= r_ovr | w_ovr_set;
      r_rd_valid <= w_grant & {NUM_CORES{w_sel_rd}};
      r_wr_done  <= w_grant & {NUM_CORES{w_sel_wr}};
      if (w_gnt_any) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  // Stage 2: completion pulses and status
  assign o_rd_valid = r_rd_valid;
  assign o_wr_done  = r_wr_done;
  assign o_overrun  = r_ovr;
  assign o_busy     = (|r_pend) | (|r_rd_valid) | (|r_wr_done);

endmodule

// File: tb/tb_dram_responder.sv
// Randomized and directed bench for dram_responder against a transaction-level model
// of request edges, round-robin service order and a sparse memory image.
module tb_dram_responder;

  localparam int NC    = 4;
  localparam int AW    = 12;
  localparam int DEPTH = 1 << AW;

  logic              clk;
  logic              rst_n;
  logic [16*NC-1:0]  i_dram_addr;
  logic [2*NC-1:0]   i_dram_read;
  logic [2*NC-1:0]   i_dram_write;
  logic [8*NC-1:0]   i_dram_out;
  logic [8*NC-1:0]   o_dram_in;
  logic [NC-1:0]     o_rd_valid;
  logic [NC-1:0]     o_wr_done;
  logic [NC-1:0]     o_overrun;
  logic              o_busy;

  logic [1:0]  b_rd   [NC];
  logic [1:0]  b_wr   [NC];
  logic [15:0] b_addr [NC];
  logic [7:0]  b_data [NC];

  always_comb begin
    for (int p = 0; p < NC; p++) begin
      i_dram_read[2*p +: 2]   = b_rd[p];
      i_dram_write[2*p +: 2]  = b_wr[p];
      i_dram_addr[16*p +: 16] = b_addr[p];
      i_dram_out[8*p +: 8]    = b_data[p];
    end
  end

  dram_responder #(
    .NUM_CORES  (NC),
    .MEM_ADDR_W (AW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_dram_addr  (i_dram_addr),
    .i_dram_read  (i_dram_read),
    .i_dram_write (i_dram_write),
    .i_dram_out   (i_dram_out),
    .o_dram_in    (o_dram_in),
    .o_rd_valid   (o_rd_valid),
    .o_wr_done    (o_wr_done),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: pending requests as plain per-port records, memory as a sparse map.
  bit          m_prd   [NC];
  bit          m_pwr   [NC];
  bit          m_pend  [NC];
  bit          m_iswr  [NC];
  logic [15:0] m_addr  [NC];
  logic [7:0]  m_data  [NC];
  int          m_ptr;
  logic [7:0]  m_mem   [int];

  bit          e_vld   [NC];
  bit          e_done  [NC];
  bit          e_ovr   [NC];
  logic [7:0]  e_din   [NC];
  bit          e_known [NC];
  bit          e_busy;

  int cnt_vld  [NC];
  int cnt_done [NC];

  task automatic model_reset();
    for (int p = 0; p < NC; p++) begin
      m_prd[p] = 0; m_pwr[p] = 0; m_pend[p] = 0;
      e_vld[p] = 0; e_done[p] = 0; e_ovr[p] = 0;
      e_din[p] = 8'h00; e_known[p] = 1;
    end
    m_ptr  = 0;
    e_busy = 0;
  endtask

  task automatic model_step();
    bit old_pend [NC];
    int g;
    int a;
    bit re, we, any;
    g = -1;
    for (int p = 0; p < NC; p++) begin
      old_pend[p] = m_pend[p];
      e_vld[p]    = 0;
      e_done[p]   = 0;
    end
    for (int k = 0; k < NC; k++) begin
      if (g < 0 && m_pend[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
    end
    if (g >= 0) begin
      a = int'(m_addr[g]) % DEPTH;
      if (m_iswr[g]) begin
        m_mem[a]  = m_data[g];
        e_done[g] = 1;
      end else begin
        e_vld[g] = 1;
        if (m_mem.exists(a)) begin
          e_din[g]   = m_mem[a];
          e_known[g] = 1;
        end else begin
          e_known[g] = 0;
        end
      end
      m_pend[g] = 0;
      m_ptr     = (g + 1) % NC;
    end
    for (int p = 0; p < NC; p++) begin
      re  = (b_rd[p] == 2'b01) && !m_prd[p];
      we  = (b_wr[p] == 2'b01) && !m_pwr[p];
      any = re || we;
      if (any) begin
        if (old_pend[p]) begin
          e_ovr[p] = 1;
        end else begin
          m_pend[p] = 1;
          m_iswr[p] = we;
          m_addr[p] = b_addr[p];
          m_data[p] = b_data[p];
        end
        if (re && we) e_ovr[p] = 1;
      end
      if (b_rd[p][1] || b_wr[p][1]) e_ovr[p] = 1;
      m_prd[p] = (b_rd[p] == 2'b01);
      m_pwr[p] = (b_wr[p] == 2'b01);
    end
    e_busy = 0;
    for (int p = 0; p < NC; p++) begin
      if (m_pend[p] || e_vld[p] || e_done[p]) e_busy = 1;
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < NC; p++) begin
      chk($sformatf("rd_valid[%0d]", p), 32'(o_rd_valid[p]), 32'(e_vld[p]));
      chk($sformatf("wr_done[%0d]", p), 32'(o_wr_done[p]), 32'(e_done[p]));
      chk($sformatf("overrun[%0d]", p), 32'(o_overrun[p]), 32'(e_ovr[p]));
      if (e_known[p]) chk($sformatf("dram_in[%0d]", p), 32'(o_dram_in[8*p +: 8]), 32'(e_din[p]));
      if (o_rd_valid[p] === 1'b1) cnt_vld[p]++;
      if (o_wr_done[p] === 1'b1) cnt_done[p]++;
    end
    chk("busy", 32'(o_busy), 32'(e_busy));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_all();
    for (int p = 0; p < NC; p++) begin
      b_rd[p] = 2'b00;
      b_wr[p] = 2'b00;
    end
  endtask

  task automatic clr_cnt();
    for (int p = 0; p < NC; p++) begin
      cnt_vld[p]  = 0;
      cnt_done[p] = 0;
    end
  endtask

  task automatic rd_req(input int p, input logic [15:0] a);
    b_rd[p]   = 2'b01;
    b_addr[p] = a;
  endtask

  task automatic wr_req(input int p, input logic [15:0] a, input logic [7:0] d);
    b_wr[p]   = 2'b01;
    b_addr[p] = a;
    b_data[p] = d;
  endtask

  task automatic measure(output int lat [NC]);
    for (int p = 0; p < NC; p++) lat[p] = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      idle_all();
      for (int p = 0; p < NC; p++) begin
        if (o_rd_valid[p] === 1'b1 && lat[p] == 0) lat[p] = t;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat [NC];
    logic [7:0] cap;
    int k;

    rst_n = 1'b0;
    for (int p = 0; p < NC; p++) begin
      b_rd[p] = 2'b00; b_wr[p] = 2'b00; b_addr[p] = '0; b_data[p] = '0;
    end
    model_reset();
    clr_cnt();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("reset_busy", 32'(o_busy), 32'd0);
    #3 rst_n = 1'b1;

    // Prefill the low address window used by the random phase.
    for (int base = 0; base < 32; base += 4) begin
      for (int p = 0; p < NC; p++) begin
        wr_req(p, 16'(base + p), (base + p == 16'h10) ? 8'hA5 : 8'($urandom));
      end
      tick();
      idle_all();
      run(5);
    end

    // Single read, minimum latency.
    rd_req(0, 16'h0010);
    tick();
    chk("t1_early", 32'(o_rd_valid[0]), 32'd0);
    idle_all();
    tick();
    chk("t1_valid", 32'(o_rd_valid[0]), 32'd1);
    chk("t1_data", 32'(o_dram_in[7:0]), 32'hA5);
    run(2);

    // Bring pointer back to port 0, then all four ports request together twice.
    rd_req(3, 16'h0001);
    tick();
    idle_all();
    run(3);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NC; p++) rd_req(p, 16'(p + 4));
      measure(lat);
      for (int p = 0; p < NC; p++) chk($sformatf("t2_lat%0d[%0d]", r, p), 32'(lat[p]), 32'(p + 2));
    end

    // Write then read to the same address in one edge cycle.
    wr_req(1, 16'h0200, 8'h3C);
    rd_req(2, 16'h0200);
    tick();
    idle_all();
    cap = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (o_rd_valid[2] === 1'b1) cap = o_dram_in[23:16];
    end
    chk("t3_data", 32'(cap), 32'h3C);

    // Held request code gives exactly one access.
    clr_cnt();
    rd_req(0, 16'h0003);
    run(10);
    idle_all();
    run(3);
    chk("t4_one_pulse", 32'(cnt_vld[0]), 32'd1);
    chk("t4_no_ovr", 32'(o_overrun[0]), 32'd0);

    // Second edge while still pending behind other ports.
    clr_cnt();
    for (int p = 0; p < NC; p++) rd_req(p, 16'(p + 8));
    tick();
    b_rd[0] = 2'b00;
    tick();
    b_rd[0] = 2'b01;
    tick();
    idle_all();
    run(6);
    chk("t4_pend_pulse", 32'(cnt_vld[0]), 32'd1);
    chk("t4_pend_ovr", 32'(o_overrun[0]), 32'd1);

    // Read and write edges together: write wins.
    clr_cnt();
    rd_req(3, 16'h0020);
    wr_req(3, 16'h0020, 8'h77);
    tick();
    idle_all();
    run(4);
    chk("t5_no_rd", 32'(cnt_vld[3]), 32'd0);
    chk("t5_done", 32'(cnt_done[3]), 32'd1);
    chk("t5_ovr", 32'(o_overrun[3]), 32'd1);
    rd_req(2, 16'h3020);
    tick();
    idle_all();
    tick();
    chk("t5_readback", 32'(o_dram_in[23:16]), 32'h77);
    run(2);

    // Reserved code sets overrun without an access.
    clr_cnt();
    b_rd[1] = 2'b10;
    b_addr[1] = 16'h0002;
    tick();
    idle_all();
    run(3);
    chk("illegal_ovr", 32'(o_overrun[1]), 32'd1);
    chk("illegal_no_rd", 32'(cnt_vld[1]), 32'd0);

    // Randomized traffic with aliased upper address bits.
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NC; p++) begin
        k = $urandom_range(0, 99);
        b_addr[p] = {4'($urandom_range(0, 15)), 12'($urandom_range(0, 33))};
        b_data[p] = 8'($urandom);
        b_rd[p] = 2'b00;
        b_wr[p] = 2'b00;
        if (k < 25) b_rd[p] = 2'b01;
        else if (k < 45) b_wr[p] = 2'b01;
        else if (k < 47) begin b_rd[p] = 2'b01; b_wr[p] = 2'b01; end
        else if (k < 48) b_wr[p] = 2'({1'b1, 1'($urandom)});
      end
      tick();
    end
    idle_all();
    run(6);

    // Reset with requests pending; prior RAM contents survive.
    wr_req(0, 16'h0300, 8'h5A);
    tick();
    idle_all();
    run(4);
    rd_req(1, 16'h0005);
    wr_req(2, 16'h0301, 8'hEE);
    rd_req(3, 16'h0006);
    tick();
    idle_all();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("t6_rst_ovr", 32'(o_overrun), 32'd0);
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst_n = 1'b1;
    clr_cnt();
    run(6);
    chk("t6_no_vld", 32'(cnt_vld[0] + cnt_vld[1] + cnt_vld[2] + cnt_vld[3]), 32'd0);
    chk("t6_no_done", 32'(cnt_done[0] + cnt_done[1] + cnt_done[2] + cnt_done[3]), 32'd0);
    rd_req(0, 16'h0300);
    tick();
    idle_all();
    tick();
    chk("t6_valid", 32'(o_rd_valid[0]), 32'd1);
    chk("t6_data", 32'(o_dram_in[7:0]), 32'h5A);
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
